// File: rtl/sha256_if.sv
// Request/response bundle between a SHA-256 block source and the compression core.
// start is a one-cycle request honoured only while busy=0; ready is a level that stays high until the next accepted start.
interface sha256_if;
  logic         start;
  logic         init;
  logic [511:0] block;
  logic         busy;
  logic         ready;
  logic [255:0] digest;

  modport master (output start, init, block, input busy, ready, digest);
  modport slave  (input start, init, block, output busy, ready, digest);
endinterface

// File: rtl/sha256_core.sv
// SHA-256 compression core: one 512-bit block per request, ROUNDS_PER_CYCLE rounds per clock,
// message schedule generated in a sliding 16-word window, chaining value held in the digest register.
module sha256_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  sha256_if.slave    bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUNDS = 2'd1, FINAL = 2'd2} state_t;

  localparam int         R        = ROUNDS_PER_CYCLE;
  localparam logic [5:0] RND_STEP = 6'(R);
  localparam logic [5:0] RND_LAST = 6'(64 - R);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  rnd_q, rnd_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] v_q [8];
  logic [31:0] v_d [8];
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic        ready_q, ready_d;
  logic        from_iv_q, from_iv_d;

  logic [31:0] w_t [16];
  logic [31:0] v_t [8];
  logic [31:0] t1, t2, w_new;

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    w_d       = w_q;
    v_d       = v_q;
    h_d       = h_q;
    ready_d   = ready_q;
    from_iv_d = from_iv_q;
    w_t       = w_q;
    v_t       = v_q;
    t1        = '0;
    t2        = '0;
    w_new     = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < 16; i++) w_d[i] = bus.block[511 - 32*i -: 32];
          for (int i = 0; i < 8; i++)  v_d[i] = bus.init ? IV[i] : h_q[i];
          from_iv_d = bus.init;
          rnd_d     = '0;
          ready_d   = 1'b0;
          state_d   = ROUNDS;
        end
      end
      ROUNDS: begin
        // w_t[0] is always W_t for the round being computed; the window slides one word per round.
        for (int j = 0; j < R; j++) begin
          t1 = v_t[7] + bsig1(v_t[4]) + ((v_t[4] & v_t[5]) ^ (~v_t[4] & v_t[6]))
             + K[rnd_q + 6'(j)] + w_t[0];
          t2 = bsig0(v_t[0]) + ((v_t[0] & v_t[1]) ^ (v_t[0] & v_t[2]) ^ (v_t[1] & v_t[2]));
          w_new = ssig1(w_t[14]) + w_t[9] + ssig0(w_t[1]) + w_t[0];
          for (int i = 7; i > 0; i--) v_t[i] = v_t[i-1];
          v_t[4] = v_t[4] + t1;
          v_t[0] = t1 + t2;
          for (int i = 0; i < 15; i++) w_t[i] = w_t[i+1];
          w_t[15] = w_new;
        end
        w_d   = w_t;
        v_d   = v_t;
        rnd_d = rnd_q + RND_STEP;
        if (rnd_q == RND_LAST) state_d = FINAL;
      end
      FINAL: begin
        // The chaining input is either the IV or the untouched digest register, so no copy is kept.
        for (int i = 0; i < 8; i++) h_d[i] = (from_iv_q ? IV[i] : h_q[i]) + v_q[i];
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rnd_q     <= '0;
      ready_q   <= 1'b0;
      from_iv_q <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= '0;
        h_q[i] <= IV[i];
      end
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      ready_q   <= ready_d;
      from_iv_q <= from_iv_d;
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= v_d[i];
        h_q[i] <= h_d[i];
      end
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.ready  = ready_q;
  assign bus.digest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sha256_core.sv
// Bench for sha256_core: four instances (1, 2, 4, 8 rounds per cycle) share one stimulus stream;
// expected digests and completion edges are queued per instance and checked when ready rises.
module tb_sha256_core;

  localparam logic [255:0] IV_DIG    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2  = {448'h0, 64'h1c0};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus, per-instance start
  logic [3:0]   start_v = 4'h0;
  logic         init = 1'b0;
  logic [511:0] block = '0;

  logic [3:0]   rdy, bsy;
  logic [255:0] dig [4];
  logic [1:0]   st  [4];

  sha256_if bus1 ();
  sha256_if bus2 ();
  sha256_if bus4 ();
  sha256_if bus8 ();

  assign bus1.start = start_v[0]; assign bus1.init = init; assign bus1.block = block;
  assign bus2.start = start_v[1]; assign bus2.init = init; assign bus2.block = block;
  assign bus4.start = start_v[2]; assign bus4.init = init; assign bus4.block = block;
  assign bus8.start = start_v[3]; assign bus8.init = init; assign bus8.block = block;

  assign rdy = {bus8.ready, bus4.ready, bus2.ready, bus1.ready};
  assign bsy = {bus8.busy,  bus4.busy,  bus2.busy,  bus1.busy};
  assign dig[0] = bus1.digest;
  assign dig[1] = bus2.digest;
  assign dig[2] = bus4.digest;
  assign dig[3] = bus8.digest;

  sha256_core #(.ROUNDS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1), .dbg_state(st[0]));
  sha256_core #(.ROUNDS_PER_CYCLE(2)) dut2 (.clk(clk), .reset(rst_n), .bus(bus2), .dbg_state(st[1]));
  sha256_core #(.ROUNDS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(rst_n), .bus(bus4), .dbg_state(st[2]));
  sha256_core #(.ROUNDS_PER_CYCLE(8)) dut8 (.clk(clk), .reset(rst_n), .bus(bus8), .dbg_state(st[3]));

  // scoreboard
  logic [255:0] exp_q [4][$];
  int           due_q [4][$];
  bit           chk_q [4][$];
  logic [255:0] cur_dig [4];
  bit   [3:0]   cur_known = 4'hF;
  logic [3:0]   rdy_prev = 4'h0;
  int checks = 0;
  int errors = 0;

  task automatic expect_vec(input string name, input int k, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, k, act, exp);
    end
  endtask

  task automatic expect_int(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d want %0d", name, k, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [255:0] e;
    int           d;
    bit           m;
    for (int k = 0; k < 4; k++) begin
      if (rdy[k] && !rdy_prev[k]) begin
        if (exp_q[k].size() == 0) begin
          expect_int("unexpected_ready", k, 1, 0);
        end else begin
          e = exp_q[k].pop_front();
          d = due_q[k].pop_front();
          m = chk_q[k].pop_front();
          expect_int("ready_edge", k, cyc, d);
          if (m) begin
            expect_vec("digest", k, dig[k], e);
            cur_dig[k]   = e;
            cur_known[k] = 1'b1;
          end else begin
            cur_known[k] = 1'b0;
          end
        end
      end
      if (bsy[k] && cur_known[k]) expect_vec("digest_hold_busy", k, dig[k], cur_dig[k]);
      rdy_prev[k] = rdy[k];
    end
  end

  // drivers
  task automatic start_op(input logic [511:0] blk, input logic ini, input logic [255:0] exp_dig,
                          input logic [3:0] push_mask);
    int t;
    @(negedge clk);
    block   = blk;
    init    = ini;
    start_v = 4'hF;
    t       = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (push_mask[k]) begin
        exp_q[k].push_back(exp_dig);
        due_q[k].push_back(t + (64 >> k) + 1);
        chk_q[k].push_back(1'b1);
      end
    end
    @(negedge clk);
    start_v = 4'h0;
  endtask

  task automatic check_idle_hold();
    repeat (70) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      expect_int("ready_hold", k, int'(rdy[k]), 1);
      if (cur_known[k]) expect_vec("digest_hold_idle", k, dig[k], cur_dig[k]);
    end
  endtask

  task automatic check_reset_state();
    for (int k = 0; k < 4; k++) begin
      expect_int("reset_ready", k, int'(rdy[k]), 0);
      expect_int("reset_busy", k, int'(bsy[k]), 0);
      expect_int("reset_state", k, int'(st[k]), 0);
      expect_vec("reset_digest", k, dig[k], IV_DIG);
    end
  endtask

  initial begin
    int t;
    for (int k = 0; k < 4; k++) cur_dig[k] = IV_DIG;

    repeat (3) @(negedge clk);
    check_reset_state();
    #2 rst_n = 1'b1;

    // empty message and "abc", all instances in parallel
    start_op(EMPTY_BLK, 1'b1, EMPTY_DIG, 4'hF);
    check_idle_hold();
    start_op(ABC_BLK, 1'b1, ABC_DIG, 4'hF);
    check_idle_hold();

    // "abc" again, from a different previous digest, with a stray start and block change mid-ROUNDS
    start_op(EMPTY_BLK, 1'b1, EMPTY_DIG, 4'hF);
    check_idle_hold();
    start_op(ABC_BLK, 1'b1, ABC_DIG, 4'hF);
    @(negedge clk);
    @(negedge clk);
    block   = EMPTY_BLK;
    init    = 1'b1;
    start_v = 4'hF;
    @(negedge clk);
    start_v = 4'h0;
    block   = {16{32'hdeadbeef}};
    check_idle_hold();

    // two-block message; second block accepted in the first IDLE cycle of each instance
    @(negedge clk);
    block   = TWO_BLK1;
    init    = 1'b1;
    start_v = 4'hF;
    t       = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      exp_q[k].push_back('0);
      due_q[k].push_back(t + (64 >> k) + 1);
      chk_q[k].push_back(1'b0);
      exp_q[k].push_back(TWO_DIG);
      due_q[k].push_back(t + 2 * (64 >> k) + 3);
      chk_q[k].push_back(1'b1);
    end
    @(negedge clk);
    block = TWO_BLK2;
    init  = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (c == (64 >> k) + 2) start_v[k] = 1'b0;
    end
    check_idle_hold();

    // reset around round 30 of the slow instance: 4- and 8-round instances finish first
    start_op(ABC_BLK, 1'b1, ABC_DIG, 4'b1100);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cur_dig[k]   = IV_DIG;
      cur_known[k] = 1'b1;
    end
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    #2 rst_n = 1'b1;
    start_op(ABC_BLK, 1'b0, ABC_DIG, 4'hF);
    check_idle_hold();

    for (int k = 0; k < 4; k++) expect_int("queue_drained", k, exp_q[k].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sha256_core.md
SHA256_CORE -- requirements
Module: sha256_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, number of compression rounds per clock; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clk, input, 1, single clock for all state; rising-edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to compress one block; sampled on a rising edge.
REQ-005 SHALL have port init, input, 1, qualifies start: 1 = chain from IV, 0 = chain from current digest.
REQ-006 SHALL have port block, input, 512, message block; block[511:480] = W0, big-endian, already padded.
REQ-007 SHALL have port busy, output, 1, high while a block is being processed.
REQ-008 SHALL have port ready, output, 1, level signal: digest valid for the last accepted block.
REQ-009 SHALL have port digest, output, 256, chaining value; digest[255:224] = H0 ... digest[31:0] = H7.

Function
REQ-010 SHALL implement FIPS 180-4 SHA-256 compression with all 64 K constants and the 8 IV words internal.
REQ-011 SHALL use FSM states IDLE, ROUNDS, FINAL.
REQ-012 SHALL accept start only in IDLE; in that case it captures block into a 16-word schedule window and round counter = 0.
REQ-013 SHALL load working vars a..h from IV if init=1, otherwise from the digest register; SHALL then set busy=1, clear ready and go to ROUNDS.
REQ-014 SHALL ignore start in ROUNDS or FINAL, with no effect on state, ready or digest.
REQ-015 SHALL, in ROUNDS, execute ROUNDS_PER_CYCLE chained rounds per cycle.
REQ-016 SHALL generate W16..W63 on the fly with a sliding 16-word window: sigma0 = ROTR7^ROTR18^SHR3, sigma1 = ROTR17^ROTR19^SHR10.
REQ-017 SHALL use Ch = (e&f)^(~e&g), Maj = (a&b)^(a&c)^(b&c), Sigma0 = ROTR2^ROTR13^ROTR22, Sigma1 = ROTR6^ROTR11^ROTR25.
REQ-018 SHALL perform all additions modulo 2^32, with carries discarded.
REQ-019 SHALL advance the round counter by ROUNDS_PER_CYCLE per cycle; after round 63 completes, SHALL go to FINAL.
REQ-020 SHALL, in FINAL, update digest word i = chaining word i + working var i (mod 2^32), set ready=1, set busy=0 and return to IDLE, all on one edge.
REQ-021 Latency: if start is sampled on edge T, digest and ready SHALL update on edge T + 64/ROUNDS_PER_CYCLE + 1 (65 edges for R=1, 9 edges for R=8).
REQ-022 SHALL hold digest and ready stable in IDLE until the next accepted start.
REQ-023 SHALL allow back-to-back operation: start may be accepted in the first IDLE cycle after FINAL.
REQ-024 SHALL keep digest equal to the previous value throughout ROUNDS; only FINAL writes it.
REQ-025 SHALL sample the block input only on the accepting edge; block changes during busy SHALL have no effect.

Reset
REQ-026 While reset=0, SHALL hold state = IDLE, busy=0, ready=0, round counter = 0, schedule and working regs = 0, and digest = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
REQ-027 SHALL act on reset asynchronously; reset asserted mid-ROUNDS or in FINAL SHALL abort the operation with no digest update.
REQ-028 SHALL make start with init=0 straight after reset equivalent to init=1.

Verification
REQ-029 Directed test, empty message: block = 80000000 then 15 zero words, init=1, ROUNDS_PER_CYCLE=1 -> ready on edge T+65; digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-030 Directed test, "abc": block = 61626380, 13 zero words, then 00000000 00000018, init=1 -> digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; repeat for R = 2, 4, 8 with latency 33, 17, 9.
REQ-031 Directed test, two-block 448-bit NIST message "abcdbcdecdefdefg...nopq": block 1 with init=1, block 2 back-to-back with init=0 -> digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-032 Directed test, start pulsed and block changed mid-ROUNDS of the "abc" run -> no effect; the "abc" digest is still produced at the same edge.
REQ-033 Directed test, reset asserted at round 30, then released, then "abc" started with init=0 -> ready=0 and digest = IV during reset; final digest = the "abc" value.
